// File: rtl/arith_pkg.sv
// arith_pkg
//   Shared definitions for the datapath arithmetic unit (multiplier, divider
//   and later arithmetic blocks).
//   - DEFAULT_WIDTH : default operand width for the arithmetic blocks.
//   - QUOT_SAT      : saturated quotient (all ones) at the default width.
//   - div_state_t   : divider control states IDLE / RUN / DONE.
package arith_pkg;

    localparam int DEFAULT_WIDTH = 32;

    localparam logic [DEFAULT_WIDTH-1:0] QUOT_SAT = '1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } div_state_t;

endpackage

// File: rtl/seq_restoring_divider_div_step.sv
// div_step
//   One combinational restoring-division step.
//   Shifts the next dividend bit into the partial remainder and subtracts
//   the divisor.  The subtraction is an add of the inverted divisor with a
//   carry-in of 1; the carry out of the WIDTH+1-bit sum is set exactly when
//   the difference is non-negative, and that carry is the quotient bit.
//   Ports:
//     r      in  WIDTH    partial remainder (its WIDTH+1th bit is always 0)
//     q_msb  in  1        next dividend bit, the MSB of the quotient shifter
//     d      in  WIDTH    divisor
//     r_next out WIDTH+1  restored or reduced partial remainder
//     qbit   out 1        quotient bit produced by this step
module div_step
    import arith_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic [WIDTH-1:0] r,
    input  logic             q_msb,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH:0]   r_next,
    output logic             qbit
);

    logic [WIDTH:0]   s;
    logic [WIDTH:0]   d_inv;
    logic [WIDTH+1:0] sum;

    always_comb begin
        s      = {r, q_msb};
        d_inv  = ~{1'b0, d};
        // Extra top bit of sum captures the carry out of the WIDTH+1-bit add.
        sum    = {1'b0, s} + {1'b0, d_inv} + {{(WIDTH+1){1'b0}}, 1'b1};
        qbit   = sum[WIDTH+1];
        r_next = qbit ? sum[WIDTH:0] : s;
    end

endmodule

// File: rtl/seq_restoring_divider.sv
// seq_restoring_divider
//   Iterative unsigned restoring divider: a 2*WIDTH-bit dividend divided by a
//   WIDTH-bit divisor, one quotient bit per clock.  Divide-by-zero and
//   quotient overflow are detected at acceptance and finish in one cycle
//   with a saturated quotient.
//   Handshake: start is taken on a rising edge whenever the block is not
//   busy (IDLE or DONE); dividend/divisor are sampled on that same edge and
//   ignored afterwards.  done pulses for one cycle with quotient, remainder
//   and flags valid; start may be high during that cycle for back-to-back
//   operation.  Results hold until the next completion.
//   Ports:
//     clk, rst_n   clock, asynchronous active-low reset
//     start        operation request
//     dividend     2*WIDTH-bit unsigned dividend
//     divisor      WIDTH-bit unsigned divisor
//     busy         high while iterating (RUN)
//     done         one-cycle completion pulse (DONE)
//     quotient     registered quotient
//     remainder    registered remainder
//     div_by_zero  last operation had divisor == 0
//     overflow     last operation's quotient did not fit in WIDTH bits
//     state_dbg    current control state
module seq_restoring_divider
    import arith_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [2*WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0]   divisor,
    output logic               busy,
    output logic               done,
    output logic [WIDTH-1:0]   quotient,
    output logic [WIDTH-1:0]   remainder,
    output logic               div_by_zero,
    output logic               overflow,
    output div_state_t         state_dbg
);

    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    div_state_t       state;
    div_state_t       next_state;

    logic [WIDTH-1:0] r_q;
    logic [WIDTH-1:0] q_q;
    logic [WIDTH-1:0] d_q;
    logic [CNT_W-1:0] cnt;

    logic [WIDTH-1:0] div_hi;
    logic [WIDTH-1:0] div_lo;
    logic             accept;
    logic             is_dbz;
    logic             is_ovf;
    logic             last_step;

    logic [WIDTH:0]   step_r;
    logic             step_qbit;
    logic             step_r_msb_unused;

    assign div_hi    = dividend[2*WIDTH-1:WIDTH];
    assign div_lo    = dividend[WIDTH-1:0];
    assign accept    = start && (state != RUN);
    assign is_dbz    = (divisor == '0);
    // With a non-zero divisor, the quotient fits in WIDTH bits exactly when
    // the high half of the dividend is below the divisor.
    assign is_ovf    = !is_dbz && (div_hi >= divisor);
    assign last_step = (state == RUN) && (cnt == CNT_LAST);

    div_step #(.WIDTH(WIDTH)) u_step (
        .r      (r_q),
        .q_msb  (q_q[WIDTH-1]),
        .d      (d_q),
        .r_next (step_r),
        .qbit   (step_qbit)
    );

    // R < D holds every step, so the step result's top bit is always 0.
    assign step_r_msb_unused = step_r[WIDTH];

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic
    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (start) begin
                    next_state = (is_dbz || is_ovf) ? DONE : RUN;
                end
            end
            RUN: begin
                if (cnt == CNT_LAST) begin
                    next_state = DONE;
                end
            end
            DONE: begin
                if (start) begin
                    next_state = (is_dbz || is_ovf) ? DONE : RUN;
                end else begin
                    next_state = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    // Outputs decoded from the registered state only
    always_comb begin
        busy      = (state == RUN);
        done      = (state == DONE);
        state_dbg = state;
    end

    // Datapath: operand registers, step counter and result registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_q         <= '0;
            q_q         <= '0;
            d_q         <= '0;
            cnt         <= '0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
            overflow    <= 1'b0;
        end else if (accept) begin
            if (is_dbz) begin
                quotient    <= '1;
                remainder   <= div_lo;
                div_by_zero <= 1'b1;
                overflow    <= 1'b0;
            end else if (is_ovf) begin
                quotient    <= '1;
                remainder   <= '0;
                div_by_zero <= 1'b0;
                overflow    <= 1'b1;
            end else begin
                r_q <= div_hi;
                q_q <= div_lo;
                d_q <= divisor;
                cnt <= '0;
            end
        end else if (state == RUN) begin
            r_q <= step_r[WIDTH-1:0];
            q_q <= {q_q[WIDTH-2:0], step_qbit};
            cnt <= cnt + CNT_W'(1);
            if (last_step) begin
                quotient    <= {q_q[WIDTH-2:0], step_qbit};
                remainder   <= step_r[WIDTH-1:0];
                div_by_zero <= 1'b0;
                overflow    <= 1'b0;
            end
        end
    end

endmodule
